// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: signal bundle between the core's fetch/data ports, the
// arbiter and the unified memory.
//   fetch  : if_req, if_addr in; if_rdata, if_ready out
//   data   : d_rd, d_wr, d_addr, d_wdata, d_funct3 in; d_rdata, d_ready out
//   status : err out (timed-out access, coincident with ready)
//   memory : mem_en, mem_we, mem_addr, mem_wdata, mem_size out; mem_rdata, mem_ack in
// master is the arbiter's view, slave the view of the core and memory around it.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_funct3, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, err, mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );
    modport slave (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_funct3, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, err, mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store, data first with bounded fetch starvation and an access timeout.
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : mem_port_arbiter_if.master carrying fetch, data and memory signals
// Every output is registered; one access costs grant, busy (>=1 cycle), response.
module mem_port_arbiter #(
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic          d_req, grant_d, grant_if, busy, expired, done, tout;

    always_comb begin
        d_req    = bus.d_rd | bus.d_wr;
        grant_d  = state == IDLE && d_req && (!bus.if_req || bcnt < BW'(MAX_D_BURST));
        grant_if = state == IDLE && !grant_d && bus.if_req;
        busy     = state == BUSY_IF || state == BUSY_D;
        expired  = tcnt == TW'(TIMEOUT - 1);
        done     = busy && (bus.mem_ack || expired);
        // an ack arriving on the last allowed cycle still counts as success
        tout     = busy && !bus.mem_ack && expired;
        state_nx = grant_d ? BUSY_D : grant_if ? BUSY_IF : done ? RESP : state == RESP ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_ready  <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_size  <= '0;
            bcnt          <= '0;
            tcnt          <= '0;
        end else begin
            bus.if_ready <= done && state == BUSY_IF;
            bus.d_ready  <= done && state == BUSY_D;
            bus.err      <= tout;
            tcnt         <= busy && !done ? tcnt + 1'b1 : '0;
            if (grant_d || grant_if) begin
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= grant_d && bus.d_wr;
                bus.mem_addr  <= grant_d ? bus.d_addr : bus.if_addr;
                bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
                bus.mem_size  <= grant_d ? bus.d_funct3 : 3'b010;
                // only data wins taken over a waiting fetch count toward its starvation bound
                bcnt <= grant_d && bus.if_req ? (bcnt == BW'(MAX_D_BURST) ? bcnt : bcnt + 1'b1) : '0;
            end
            if (done) bus.mem_en <= 1'b0;
            if (done && state == BUSY_IF) bus.if_rdata <= tout ? '0 : bus.mem_rdata;
            // stores leave the last load value in place unless they time out
            if (done && state == BUSY_D && (tout || !bus.mem_we)) bus.d_rdata <= tout ? '0 : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter, using a table of
// single accesses, hand sequences for reset/priority/starvation, and a random
// phase checked against a schedule-based model of grants and responses.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          lat;
        logic [31:0] mrd;
        logic        exp_we;
        logic [2:0]  exp_size;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    int          next_arb, e_edge, done_e, ack_e, lat, streak, r;
    bit          act, port_d, exp_we, exp_en, is_done;
    logic [31:0] exp_addr, exp_wdata, exp_if_rd, exp_d_rd;
    logic [2:0]  exp_size;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v === exp_v) passed++;
        else $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_funct3 = '0;
        bus.mem_rdata = '0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_vec(input int idx, input vec_t v);
        int en_n = 0;
        bit got = 0;
        bit stable = 1;
        bus.if_req = v.fetch;
        bus.if_addr = v.addr;
        bus.d_rd = v.rd;
        bus.d_wr = v.wr;
        bus.d_addr = v.addr;
        bus.d_wdata = v.wdata;
        bus.d_funct3 = v.f3;
        bus.mem_rdata = v.mrd;
        for (int c = 0; c < 40 && !got; c++) begin
            bus.mem_ack = bus.mem_en && (en_n - 1 == v.lat);
            tick();
            if (bus.mem_en) begin
                en_n++;
                if (bus.mem_addr !== v.addr || bus.mem_we !== v.exp_we || bus.mem_size !== v.exp_size ||
                    (!v.fetch && bus.mem_wdata !== v.wdata)) stable = 0;
            end
            if (bus.if_ready || bus.d_ready) begin
                got = 1;
                chk($sformatf("vec%0d ready port", idx), {30'd0, bus.if_ready, bus.d_ready}, v.fetch ? 32'd2 : 32'd1);
                chk($sformatf("vec%0d err", idx), 32'(bus.err), 32'(v.exp_err));
                chk($sformatf("vec%0d rdata", idx), v.fetch ? bus.if_rdata : bus.d_rdata, v.exp_rdata);
                chk($sformatf("vec%0d mem_en low at ready", idx), 32'(bus.mem_en), 32'd0);
            end
        end
        bus.mem_ack = 1'b0;
        chk($sformatf("vec%0d completed", idx), 32'(got), 32'd1);
        chk($sformatf("vec%0d request fields", idx), 32'(stable), 32'd1);
        chk($sformatf("vec%0d mem_en cycles", idx), en_n, v.lat > 15 ? 16 : v.lat + 1);
        idle_inputs();
        tick();
        chk($sformatf("vec%0d ready pulse width", idx), {30'd0, bus.if_ready | bus.d_ready, bus.err}, 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic prev;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'd0, 0, 32'h0000_0013, 1'b0, 3'b010, 1'b0, 32'h0000_0013};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b010, 0, 32'h1122_3344, 1'b0, 3'b010, 1'b0, 32'h1122_3344};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3'b000, 0, 32'hCAFE_F00D, 1'b1, 3'b000, 1'b0, 32'h1122_3344};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0045, 32'h0, 3'b100, 3, 32'h0000_00AB, 1'b0, 3'b100, 1'b0, 32'h0000_00AB};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, 3'b010, 1, 32'h9999_9999, 1'b1, 3'b010, 1'b0, 32'h0000_00AB};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_004C, 32'h0, 3'b001, 15, 32'h55AA_55AA, 1'b0, 3'b001, 1'b0, 32'h55AA_55AA};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 3'b010, 16, 32'h7777_7777, 1'b0, 3'b010, 1'b1, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 3'd0, 20, 32'h8888_8888, 1'b0, 3'b010, 1'b1, 32'h0};

        idle_inputs();
        rst = 1'b0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        bus.mem_rdata = 32'h0050_0093;
        tick();
        tick();
        chk("reset mem_en", 32'(bus.mem_en), 32'd0);
        chk("reset mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset mem_wdata", bus.mem_wdata, 32'd0);
        chk("reset mem_size", 32'(bus.mem_size), 32'd0);
        chk("reset if_ready", 32'(bus.if_ready), 32'd0);
        chk("reset d_ready", 32'(bus.d_ready), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk("reset if_rdata", bus.if_rdata, 32'd0);
        chk("reset d_rdata", bus.d_rdata, 32'd0);
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        chk("first grant mem_en", 32'(bus.mem_en), 32'd1);
        chk("first grant mem_addr", bus.mem_addr, 32'h80);
        chk("first grant mem_size", 32'(bus.mem_size), 32'd2);
        chk("first grant mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("first fetch if_ready", 32'(bus.if_ready), 32'd1);
        chk("first fetch if_rdata", bus.if_rdata, 32'h0050_0093);
        bus.if_req = 1'b0;
        tick();
        chk("first fetch ready pulse", 32'(bus.if_ready), 32'd0);
        idle_inputs();
        tick();

        for (int i = 0; i < 8; i++) do_vec(i, vecs[i]);

        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_rd = 1'b1;
        bus.d_addr = 32'h40;
        bus.d_funct3 = 3'b010;
        bus.mem_rdata = 32'h0BAD_F00D;
        bus.mem_ack = 1'b1;
        tick();
        chk("simul first grant addr", bus.mem_addr, 32'h40);
        chk("simul first grant we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("simul d_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd1);
        chk("simul d_rdata", bus.d_rdata, 32'h0BAD_F00D);
        bus.d_rd = 1'b0;
        tick();
        chk("simul no grant in resp", 32'(bus.mem_en), 32'd0);
        tick();
        chk("simul fetch grant addr", {31'd0, bus.mem_en} | (bus.mem_addr == 32'h200 ? 32'd2 : 32'd0), 32'd3);
        tick();
        chk("simul if_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd2);
        bus.if_req = 1'b0;
        tick();

        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_rd = 1'b1;
        bus.d_addr = 32'h40;
        bus.mem_ack = 1'b1;
        k = 0;
        prev = 1'b0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            tick();
            if (bus.mem_en && !prev) begin
                chk($sformatf("starve grant%0d is data", k), 32'(bus.mem_addr == 32'h40), 32'((k % 5) != 4));
                k++;
            end
            prev = bus.mem_en;
        end
        chk("starve grant count", k, 10);

        do_reset();
        bus.d_rd = 1'b1;
        bus.d_addr = 32'h60;
        tick();
        chk("midreset granted", 32'(bus.mem_en), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("midreset mem_en dropped", 32'(bus.mem_en), 32'd0);
        chk("midreset no d_ready", 32'(bus.d_ready), 32'd0);
        rst = 1'b1;
        bus.d_rd = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        chk("stale ack no ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
        tick();
        chk("stale ack no ready 2", {29'd0, bus.if_ready, bus.d_ready, bus.mem_en}, 32'd0);

        do_reset();
        next_arb = 0;
        e_edge = -1;
        done_e = -1;
        ack_e = -1;
        lat = 0;
        streak = 0;
        act = 0;
        port_d = 0;
        exp_we = 0;
        exp_addr = '0;
        exp_wdata = '0;
        exp_size = '0;
        exp_if_rd = '0;
        exp_d_rd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(bus.d_rd || bus.d_wr) && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 3);
                bus.d_rd = r != 1;
                bus.d_wr = r == 1 || r == 3;
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
                bus.d_funct3 = 3'($urandom_range(0, 7));
            end
            bus.mem_ack = act ? n == ack_e : $urandom_range(0, 5) == 0;
            if (!act && n >= next_arb && (bus.if_req || bus.d_rd || bus.d_wr)) begin
                port_d = (bus.d_rd || bus.d_wr) && (!bus.if_req || streak < 4);
                streak = port_d && bus.if_req ? streak + 1 : 0;
                exp_addr = port_d ? bus.d_addr : bus.if_addr;
                exp_we = port_d && bus.d_wr;
                exp_size = port_d ? bus.d_funct3 : 3'b010;
                exp_wdata = bus.d_wdata;
                lat = $urandom_range(0, 3) == 0 ? $urandom_range(10, 20) : $urandom_range(0, 3);
                e_edge = n;
                done_e = n + 1 + (lat > 15 ? 15 : lat);
                ack_e = lat > 15 ? -1 : n + 1 + lat;
                next_arb = done_e + 2;
                act = 1;
                bus.mem_rdata = $urandom;
            end
            tick();
            exp_en = act && n >= e_edge && n < done_e;
            is_done = act && n == done_e;
            if (is_done) begin
                if (!port_d) exp_if_rd = lat > 15 ? 32'd0 : bus.mem_rdata;
                else if (lat > 15) exp_d_rd = 32'd0;
                else if (!exp_we) exp_d_rd = bus.mem_rdata;
            end
            chk($sformatf("rnd%0d mem_en", n), 32'(bus.mem_en), 32'(exp_en));
            chk($sformatf("rnd%0d if_ready", n), 32'(bus.if_ready), 32'(is_done && !port_d));
            chk($sformatf("rnd%0d d_ready", n), 32'(bus.d_ready), 32'(is_done && port_d));
            chk($sformatf("rnd%0d err", n), 32'(bus.err), 32'(is_done && lat > 15));
            chk($sformatf("rnd%0d if_rdata", n), bus.if_rdata, exp_if_rd);
            chk($sformatf("rnd%0d d_rdata", n), bus.d_rdata, exp_d_rd);
            if (exp_en) begin
                chk($sformatf("rnd%0d mem_addr", n), bus.mem_addr, exp_addr);
                chk($sformatf("rnd%0d mem_we", n), 32'(bus.mem_we), 32'(exp_we));
                chk($sformatf("rnd%0d mem_size", n), 32'(bus.mem_size), 32'(exp_size));
                if (port_d) chk($sformatf("rnd%0d mem_wdata", n), bus.mem_wdata, exp_wdata);
            end
            if (is_done) begin
                act = 0;
                if (port_d) begin
                    bus.d_rd = 1'b0;
                    bus.d_wr = 1'b0;
                end else bus.if_req = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store data port of the RISC-V core. This replaces the separate instruction and data memories.
- Arbitrates between the two ports and drives a registered request/acknowledge handshake to a variable-latency memory.
- Returns read data with a one-cycle ready pulse to the winning port.
- Gives data priority, with a bounded-starvation guarantee for fetch and a timeout on unanswered memory requests.

Parameters:
- MAX_D_BURST, 4: max consecutive data grants while fetch is pending before fetch is forced to win.
- TIMEOUT, 16: cycles mem_en may stay high without mem_ack before the access is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request, held high until if_ready.
- if_addr  in  32  fetch byte address (the PC).
- if_rdata  out  32  fetched instruction, valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_rd  in  1  load request, held until d_ready.
- d_wr  in  1  store request, held until d_ready.
- d_addr  in  32  data byte address (ALU result).
- d_wdata  in  32  store data (rs2).
- d_funct3  in  3  access size/sign, passed through to memory.
- d_rdata  out  32  load data, valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- err  out  1  one-cycle pulse, coincident with the ready pulse, when the access timed out.
- mem_en  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  write data.
- mem_size  out  3  funct3 for the access; 3'b010 for fetches.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle access-complete.

Behaviour:
- Reset: rst sampled low at an edge forces state IDLE. All outputs go to 0: if_rdata, d_rdata, if_ready, d_ready, err, mem_en, mem_we, mem_addr, mem_wdata, mem_size. The burst counter and timeout counter also clear.
- Reset mid-access: the outstanding access is abandoned and mem_en drops. A late mem_ack arriving in IDLE is ignored.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE arbitration, sampled at the edge:
  - Data request pending (d_rd|d_wr) and (no if_req, or burst count < MAX_D_BURST): go to BUSY_D.
  - Otherwise, if if_req: go to BUSY_IF.
  - Otherwise stay in IDLE.
- Burst counter:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, and on a data grant made with if_req=0.
  - Saturates at MAX_D_BURST.
- On grant, in the same edge:
  - mem_en=1.
  - mem_addr, mem_wdata, mem_we and mem_size load from the winning port.
  - mem_we = d_wr for data, 0 for fetch.
  - mem_size = d_funct3 for data, 3'b010 for fetch.
  - d_rd and d_wr both high: treated as a write.
- BUSY_*:
  - mem_* outputs are held stable.
  - The timeout counter increments each cycle.
- mem_ack=1 in BUSY_* at an edge:
  - mem_en=0, go to RESP.
  - The port's ready = 1.
  - The port's rdata <= mem_rdata. On a store, d_rdata is unchanged.
- Timeout: counter reaches TIMEOUT-1 without ack.
  - mem_en=0, go to RESP.
  - ready=1, err=1, the port's rdata <= 0.
- mem_ack and timeout in the same cycle: the ack wins and err=0.
- RESP:
  - ready/err are high for exactly this cycle.
  - No grant is made here; requesters drop their request during this cycle.
  - Next state is IDLE. Counters for the access clear.
- Latency with a zero-wait memory (ack in the first mem_en cycle):
  - request seen at edge 0;
  - mem_en high in cycle 1;
  - ready in cycle 2;
  - next grant no earlier than the edge ending cycle 3.
- Back-to-back throughput: one access per 3 cycles, plus memory wait states.
- Only one port is ever ready in a given cycle. Ready is never asserted without a prior grant.

Test Plan:
- Reset: rst=0 for 2 cycles with if_req=1 → all outputs 0. Release with mem_ack tied 1 → mem_en high with mem_addr=if_addr, mem_size=3'b010. if_ready is then pulsed for exactly 1 cycle, with if_rdata=mem_rdata (e.g. 0x00500093).
- Simultaneous request: if_req=1 and d_rd=1 with d_addr=0x40, d_funct3=3'b010 → data granted first (mem_we=0, mem_addr=0x40), d_ready pulses; the fetch is then granted and if_ready pulses.
- Store: d_wr=1, d_addr=0x44, d_wdata=0xDEADBEEF, d_funct3=3'b000 → mem_we=1, mem_wdata=0xDEADBEEF, mem_size=3'b000; d_ready pulses; d_rdata unchanged.
- Starvation: continuous d_rd plus if_req, MAX_D_BURST=4 → exactly 4 data grants, then 1 fetch grant; the pattern repeats.
- Timeout: mem_ack held 0 after a grant, TIMEOUT=16 → mem_en high for 16 cycles then low; the port's ready and err pulse together; rdata=0.
- Reset mid-access: rst=0 during BUSY_D → mem_en=0 the next cycle, no d_ready. A stale mem_ack after reset release produces no ready.
